// File: rtl/bcd_to_bin_if.sv
// Request/result bundle for the BCD-to-binary converter: start + packed digits in, result/status out.
// No backpressure; the requester watches busy and the single-cycle done pulse.
interface bcd_to_bin_if #(
   parameter int DIGITS = 8,
   parameter int WIDTH  = 28
);
   logic                  start;
   logic [4*DIGITS-1:0]   bcd_in;
   logic [WIDTH-1:0]      binario;
   logic                  busy;
   logic                  done;
   logic                  erro;

   modport master (
      output start,
      output bcd_in,
      input  binario,
      input  busy,
      input  done,
      input  erro
   );

   modport slave (
      input  start,
      input  bcd_in,
      output binario,
      output busy,
      output done,
      output erro
   );
endinterface

// File: rtl/bcd_to_bin.sv
// Reverse double-dabble BCD-to-binary, one bit per clock: WIDTH+1 cycles to done for valid digits, 1 for blank/invalid.
// start is only honoured in IDLE; requests arriving while busy or done are dropped, never queued.
module bcd_to_bin #(
   parameter int DIGITS = 8,
   parameter int WIDTH  = 28
) (
   input  logic           clock,
   input  logic           reset,
   bcd_to_bin_if.slave    bus
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [BCD_W-1:0]   bcd_q, bcd_d;
   logic [WIDTH-1:0]   bin_q, bin_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   binario_q, binario_d;
   logic               erro_q, erro_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic               all_blank;
   logic               any_bad;
   logic [BCD_W-1:0]   bcd_shift;
   logic [WIDTH-1:0]   bin_shift;

   // Blank (every nibble F) takes priority over the invalid-digit check.
   always_comb begin
      all_blank = 1'b1;
      any_bad   = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (bus.bcd_in[4*i +: 4] != 4'hF) begin
            all_blank = 1'b0;
         end
         if (bus.bcd_in[4*i +: 4] > 4'd9) begin
            any_bad = 1'b1;
         end
      end
   end

   // Shift {bcd, bin} right one place, then correct each digit that landed at 8 or above.
   always_comb begin
      bin_shift = {bcd_q[0], bin_q[WIDTH-1:1]};
      bcd_shift = bcd_q >> 1;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd_shift[4*i +: 4] >= 4'd8) begin
            bcd_shift[4*i +: 4] = bcd_shift[4*i +: 4] - 4'd3;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      bcd_d     = bcd_q;
      bin_d     = bin_q;
      cnt_d     = cnt_q;
      binario_d = binario_q;
      erro_d    = erro_q;

      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               if (all_blank) begin
                  binario_d = '1;
                  erro_d    = 1'b0;
                  state_d   = DONE;
               end else if (any_bad) begin
                  binario_d = '1;
                  erro_d    = 1'b1;
                  state_d   = DONE;
               end else begin
                  bcd_d   = bus.bcd_in;
                  bin_d   = '0;
                  cnt_d   = '0;
                  state_d = SHIFT;
               end
            end
         end
         SHIFT: begin
            bcd_d = bcd_shift;
            bin_d = bin_shift;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               binario_d = bin_shift;
               erro_d    = 1'b0;
               state_d   = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d == SHIFT);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= IDLE;
         bcd_q     <= '0;
         bin_q     <= '0;
         cnt_q     <= '0;
         binario_q <= '0;
         erro_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         bcd_q     <= bcd_d;
         bin_q     <= bin_d;
         cnt_q     <= cnt_d;
         binario_q <= binario_d;
         erro_q    <= erro_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign bus.binario = binario_q;
   assign bus.erro    = erro_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;

endmodule

// File: tb/tb_bcd_to_bin.sv
// Directed bench for bcd_to_bin: latency, results, error/blank handling, ignored start and mid-run reset.
module tb_bcd_to_bin;

   logic clock;
   logic reset;
   int   n_vec;
   int   n_bad;

   bcd_to_bin_if intf ();

   bcd_to_bin dut (
      .clock (clock),
      .reset (reset),
      .bus   (intf)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Issues one single-cycle start and watches a fixed 40-cycle window.
   task automatic run_req(input logic [31:0] v, output int lat, output int busy_cnt,
                          output int done_cnt, output logic [27:0] bin, output logic er,
                          output logic zero);
      lat = 0; busy_cnt = 0; done_cnt = 0; bin = '0; er = 1'b0; zero = 1'b0;
      intf.bcd_in = v;
      intf.start  = 1'b1;
      for (int e = 1; e <= 40; e++) begin
         @(posedge clock);
         #1;
         if (e == 1) intf.start = 1'b0;
         if (intf.busy) busy_cnt++;
         if (intf.done) begin
            done_cnt++;
            if (lat == 0) begin
               lat  = e;
               bin  = intf.binario;
               er   = intf.erro;
               zero = (dut.bcd_q == '0);
            end
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      intf.start  = 1'b0;
      intf.bcd_in = '0;
      repeat (3) @(posedge clock);
      #1;
      n_vec++; if (intf.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", intf.busy); end
      n_vec++; if (intf.done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", intf.done); end
      n_vec++; if (intf.erro !== 1'b0) begin n_bad++; $display("FAIL reset_erro: got %b want 0", intf.erro); end
      n_vec++; if (intf.binario !== 28'h0) begin n_bad++; $display("FAIL reset_binario: got %h want 0", intf.binario); end
      reset = 1'b0;
      @(posedge clock);
      #1;
   endtask

   task automatic test_convert();
      logic [31:0] vin  [3] = '{32'h12345678, 32'h99999999, 32'h00000000};
      logic [27:0] vexp [3] = '{28'h0BC614E, 28'h5F5E0FF, 28'h0000000};
      int lat, bc, dc;
      logic [27:0] bin;
      logic er, zero;
      for (int i = 0; i < 3; i++) begin
         run_req(vin[i], lat, bc, dc, bin, er, zero);
         n_vec++; if (lat !== 29) begin n_bad++; $display("FAIL conv_latency[%h]: got %0d want 29", vin[i], lat); end
         n_vec++; if (bc !== 28) begin n_bad++; $display("FAIL conv_busy_cycles[%h]: got %0d want 28", vin[i], bc); end
         n_vec++; if (dc !== 1) begin n_bad++; $display("FAIL conv_done_pulses[%h]: got %0d want 1", vin[i], dc); end
         n_vec++; if (bin !== vexp[i]) begin n_bad++; $display("FAIL conv_binario[%h]: got %h want %h", vin[i], bin, vexp[i]); end
         n_vec++; if (er !== 1'b0) begin n_bad++; $display("FAIL conv_erro[%h]: got %b want 0", vin[i], er); end
         n_vec++; if (zero !== 1'b1) begin n_bad++; $display("FAIL conv_bcd_drained[%h]: got %b want 1", vin[i], zero); end
      end
   endtask

   task automatic test_invalid();
      int lat, bc, dc;
      logic [27:0] bin;
      logic er, zero;
      run_req(32'h1234A678, lat, bc, dc, bin, er, zero);
      n_vec++; if (lat !== 1) begin n_bad++; $display("FAIL inv_latency: got %0d want 1", lat); end
      n_vec++; if (bc !== 0) begin n_bad++; $display("FAIL inv_busy_cycles: got %0d want 0", bc); end
      n_vec++; if (er !== 1'b1) begin n_bad++; $display("FAIL inv_erro: got %b want 1", er); end
      n_vec++; if (bin !== 28'hFFFFFFF) begin n_bad++; $display("FAIL inv_binario: got %h want fffffff", bin); end
      n_vec++; if (intf.erro !== 1'b1) begin n_bad++; $display("FAIL inv_erro_hold: got %b want 1", intf.erro); end
      run_req(32'h00000042, lat, bc, dc, bin, er, zero);
      n_vec++; if (lat !== 29) begin n_bad++; $display("FAIL after_inv_latency: got %0d want 29", lat); end
      n_vec++; if (bin !== 28'h000002A) begin n_bad++; $display("FAIL after_inv_binario: got %h want 000002a", bin); end
      n_vec++; if (er !== 1'b0) begin n_bad++; $display("FAIL after_inv_erro: got %b want 0", er); end
      // Partially blank input is an invalid digit, not a blank.
      run_req(32'h0000000F, lat, bc, dc, bin, er, zero);
      n_vec++; if (er !== 1'b1) begin n_bad++; $display("FAIL part_blank_erro: got %b want 1", er); end
      n_vec++; if (lat !== 1) begin n_bad++; $display("FAIL part_blank_latency: got %0d want 1", lat); end
   endtask

   task automatic test_blank();
      int lat, bc, dc;
      logic [27:0] bin;
      logic er, zero;
      run_req(32'hFFFFFFFF, lat, bc, dc, bin, er, zero);
      n_vec++; if (lat !== 1) begin n_bad++; $display("FAIL blank_latency: got %0d want 1", lat); end
      n_vec++; if (bc !== 0) begin n_bad++; $display("FAIL blank_busy_cycles: got %0d want 0", bc); end
      n_vec++; if (dc !== 1) begin n_bad++; $display("FAIL blank_done_pulses: got %0d want 1", dc); end
      n_vec++; if (bin !== 28'hFFFFFFF) begin n_bad++; $display("FAIL blank_binario: got %h want fffffff", bin); end
      n_vec++; if (er !== 1'b0) begin n_bad++; $display("FAIL blank_erro: got %b want 0", er); end
   endtask

   task automatic test_ignore_start();
      int lat = 0;
      int dc  = 0;
      logic [27:0] bin = '0;
      intf.bcd_in = 32'h12345678;
      intf.start  = 1'b1;
      for (int e = 1; e <= 40; e++) begin
         @(posedge clock);
         #1;
         if (e == 1) intf.start = 1'b0;
         if (e == 5) begin intf.start = 1'b1; intf.bcd_in = 32'h00000001; end
         if (e == 6) intf.start = 1'b0;
         if (intf.done) begin
            dc++;
            if (lat == 0) begin lat = e; bin = intf.binario; end
         end
      end
      n_vec++; if (dc !== 1) begin n_bad++; $display("FAIL ign_done_pulses: got %0d want 1", dc); end
      n_vec++; if (lat !== 29) begin n_bad++; $display("FAIL ign_latency: got %0d want 29", lat); end
      n_vec++; if (bin !== 28'h0BC614E) begin n_bad++; $display("FAIL ign_binario: got %h want 0bc614e", bin); end
   endtask

   task automatic test_reset_mid();
      int lat, bc, dc;
      logic [27:0] bin;
      logic er, zero;
      int stray = 0;
      run_req(32'h000000B0, lat, bc, dc, bin, er, zero);
      intf.bcd_in = 32'h12345678;
      intf.start  = 1'b1;
      for (int e = 1; e <= 9; e++) begin
         @(posedge clock);
         #1;
         if (e == 1) intf.start = 1'b0;
      end
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      n_vec++; if (intf.busy !== 1'b0) begin n_bad++; $display("FAIL mid_rst_busy: got %b want 0", intf.busy); end
      n_vec++; if (intf.done !== 1'b0) begin n_bad++; $display("FAIL mid_rst_done: got %b want 0", intf.done); end
      n_vec++; if (intf.binario !== 28'h0) begin n_bad++; $display("FAIL mid_rst_binario: got %h want 0", intf.binario); end
      n_vec++; if (intf.erro !== 1'b0) begin n_bad++; $display("FAIL mid_rst_erro: got %b want 0", intf.erro); end
      for (int e = 0; e < 35; e++) begin
         @(posedge clock);
         #1;
         if (intf.done || intf.busy) stray++;
      end
      n_vec++; if (stray !== 0) begin n_bad++; $display("FAIL mid_rst_stray_activity: got %0d want 0", stray); end
      run_req(32'h00000042, lat, bc, dc, bin, er, zero);
      n_vec++; if (lat !== 29) begin n_bad++; $display("FAIL post_rst_latency: got %0d want 29", lat); end
      n_vec++; if (bin !== 28'h000002A) begin n_bad++; $display("FAIL post_rst_binario: got %h want 000002a", bin); end
   endtask

   initial begin
      n_vec = 0;
      n_bad = 0;
      reset = 1'b1;
      intf.start  = 1'b0;
      intf.bcd_in = '0;
      test_reset();
      test_convert();
      test_invalid();
      test_blank();
      test_ignore_start();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/bcd_to_bin.md
Name: bcd_to_bin

Overview:
- Sequential BCD-to-binary converter using reverse double-dabble (shift right, subtract 3 from any digit ≥ 8), one bit per clock.
- Performs the inverse of the display-path binary-to-BCD conversion.
- Converts 8 decimal digits entered on the keypad/switch path into a 28-bit binary value for the datapath.
- Uses the same blank convention as the display path: all-ones means "apagado" (display blanked).

Parameters:
- DIGITS, 8, number of BCD digits on bcd_in.
- WIDTH, 28, binary result width; also the number of shift iterations. Must satisfy 10^DIGITS − 1 < 2^WIDTH.

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a conversion; sampled only in IDLE.
- bcd_in  input  4*DIGITS  packed digits; digit 7 (most significant) in [31:28], digit 0 in [3:0].
- binario  output  WIDTH  converted value; holds the last result until the next completion.
- busy  output  1  high while a conversion is in progress (state SHIFT).
- done  output  1  one-cycle pulse when binario/erro are updated.
- erro  output  1  high when the last request had an invalid digit; holds until the next completion.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (any state, including mid-conversion):
  - state = IDLE; binario = 0, busy = 0, done = 0, erro = 0.
  - Internal shift registers cleared; any in-flight conversion is discarded with no done pulse.
- States: IDLE, SHIFT, DONE.
- IDLE, busy = 0. On an edge with start = 1, bcd_in is evaluated in priority order:
  - (a) Every digit = 4'hF (blank): load binario = all ones (28'hFFFFFFF), erro = 0, go to DONE.
  - (b) Otherwise, any digit > 9: load binario = all ones, erro = 1, go to DONE.
  - (c) Otherwise: load bcd_reg = bcd_in, bin_reg = 0, counter = 0, go to SHIFT.
- SHIFT, busy = 1. Each cycle:
  - {bcd_reg, bin_reg} shifts right by 1; the LSB of bcd_reg enters the MSB of bin_reg.
  - Then every 4-bit digit of the shifted bcd_reg that is ≥ 8 has 3 subtracted, all digits in parallel within the same cycle.
  - counter increments.
  - When the counter reaches WIDTH−1 on this edge, binario = the new bin_reg, erro = 0, go to DONE.
- DONE: done = 1 for exactly this cycle, busy = 0; next state is IDLE unconditionally.
- Latency from the edge sampling start to done high:
  - valid input: WIDTH+1 cycles (29 at the defaults).
  - blank or invalid input: 1 cycle.
- start while in SHIFT or DONE is ignored, with no queuing. The minimum request spacing for valid input is therefore WIDTH+2 cycles.
- bcd_in is sampled only on the accepting edge; later changes to bcd_in do not affect the conversion in progress.
- Width rules:
  - Digit subtract is 4-bit and never underflows, because it applies only when the digit is ≥ 8.
  - Maximum valid input 99999999 = 28'h5F5E0FF < 2^28, so there is no overflow.
  - After WIDTH shifts bcd_reg must be 0. The bench asserts this; the RTL does not flag it.
- binario, erro, busy and done are all registered outputs with no combinational path from the inputs.

Test Plan:
- Reset, then bcd_in = 32'h12345678 with a 1-cycle start → busy high for 28 cycles, done 29 cycles after start, binario = 28'h0BC614E, erro = 0.
- bcd_in = 32'h99999999 → binario = 28'h5F5E0FF. bcd_in = 32'h00000000 → binario = 0. Both with done at 29 cycles and erro = 0.
- bcd_in = 32'h1234A678 → done on the next cycle, erro = 1, binario = 28'hFFFFFFF, busy never asserted. A following valid 32'h00000042 → binario = 28'h000002A, erro cleared.
- bcd_in = 32'hFFFFFFFF (blank) → done after 1 cycle, binario = 28'hFFFFFFF, erro = 0.
- Start with 32'h12345678, pulse start again and change bcd_in to 32'h00000001 at cycle 5 → second request ignored, result still 28'h0BC614E, exactly one done pulse.
- Start a conversion and assert reset at cycle 10 → next cycle busy = 0, done = 0, binario = 0, erro = 0, no done pulse. A new start then completes normally.
